logic_axi4_stream_downsizer: RTL and testbench
==============================================

Name: logic_axi4_stream_downsizer

Overview:
Single-clock AXI4-Stream width converter that splits each wide rx beat into RATIO = RX_TDATA_BYTES / TX_TDATA_BYTES narrow tx segments.
- Sits directly downstream of logic_axi4_stream_clock_crossing: that block delivers wide beats into the narrow datapath's clock domain, and this block serialises them.
- Null segments (all-zero tkeep) are removed and tlast is moved to the last real segment, so the narrow side carries no wasted beats.

Parameters:
- RX_TDATA_BYTES, 4, bytes per rx tdata; must be an integer multiple of TX_TDATA_BYTES.
- TX_TDATA_BYTES, 1, bytes per tx tdata.
- TDEST_WIDTH, 1, tdest bits, same on both sides.
- TUSER_WIDTH, 1, tuser bits, same on both sides.
- TID_WIDTH, 1, tid bits, same on both sides.
- USE_TLAST, 1, enable tlast.
- USE_TKEEP, 1, enable tkeep; when 0, tkeep is treated as all ones.
- USE_TSTRB, 1, enable tstrb; sliced per segment like tdata.

Ports:
- aclk  input  1  clock.
- areset_n  input  1  asynchronous active-low reset.
- rx  logic_axi4_stream_if rx modport  RX_TDATA_BYTES wide  input stream.
- tx  logic_axi4_stream_if tx modport  TX_TDATA_BYTES wide  output stream.

Behaviour:
- Single clock aclk; reset areset_n is asynchronous and active-low.
- Reset values: tx.tvalid=0, internal valid=0, segment index=0, pending mask=0; rx.tready=1 (combinational from empty).
- Storage: one holding register for the full rx beat, plus:
  - pending mask, RATIO bits;
  - current segment index, $clog2(RATIO) bits, minimum 1.
- Capture: on rx.tvalid && rx.tready, register the beat and compute the pending mask. Bit i is set if tkeep slice i is nonzero.
- tlast beat, mask handling:
  - Clear all bits above the highest set bit.
  - If the mask is all zero, set bit 0.
- Non-tlast beat with an all-zero mask: the beat is consumed, valid stays 0, nothing is emitted.
- Output:
  - tx.tvalid = valid.
  - tdata/tkeep/tstrb = slice[index].
  - tid/tdest/tuser are replicated from the held beat.
  - tx.tlast = held tlast && (index is the highest set pending bit).
- Advance: on tx.tvalid && tx.tready, clear pending[index] and set index to the lowest remaining set bit. When none remain, valid falls.
- rx.tready = !valid || (tx.tready && the current segment is the last pending one).
  - This gives zero-bubble back-to-back operation.
  - A simultaneous final-segment handshake and rx capture loads the new beat in the same cycle.
- Latency: a captured beat's first segment appears on tx one cycle after the rx handshake.
- Stall: while tx.tvalid && !tx.tready, all tx signals hold stable (AXI rule). tvalid never drops without a handshake.
- Reset mid-operation: the held beat is discarded immediately, and tx.tvalid goes low asynchronously.
- RATIO == 1: pure one-entry register slice with the same handshake; the null-beat rule still applies.

Optional Feature:
LOGIC_AXI4_STREAM_DOWNSIZER_SKIP_NULL_EN
- Defined: null-segment skipping and tlast relocation as described in Behaviour.
- Undefined:
  - The pending mask is always all ones, so every segment is emitted verbatim, including tkeep=0 slices.
  - tlast is asserted on segment RATIO-1 only.
  - All-zero beats emit RATIO segments.
  - The encoder logic is removed.

Decomposition:
- logic_axi4_stream_pkg holds constant function downsize_ratio(rx_bytes, tx_bytes). Elaboration fails via $error when rx_bytes is not a multiple of tx_bytes.
- One sub-module: logic_axi4_stream_downsizer_select, a combinational RATIO-bit find-first/find-last-set encoder.
  - Outputs: next index, last flag, any flag.
  - It is reused for capture-time mask trimming and for the advance step.

Test Plan:
All scenarios use RX_TDATA_BYTES=4, TX_TDATA_BYTES=1, and the macro is defined unless stated otherwise.
1. Full beat tdata=0x44332211, tkeep=0xF, tlast=1, tx.tready=1 -> tx tdata 0x11,0x22,0x33,0x44 on four consecutive cycles; tlast only on 0x44; rx.tready low for the first 3 of those cycles.
2. tkeep=0x5, tlast=0 -> tx emits 0x11 then 0x33, two beats, tlast=0. With the macro undefined -> four beats, tkeep pattern 1,0,1,0.
3. tkeep=0x3, tlast=1 -> 0x11, then 0x22 with tlast=1; segments 2 and 3 are dropped. Next rx beat is accepted in the cycle 0x22 handshakes.
4. Null beats:
   - tkeep=0x0, tlast=1 -> one tx beat with tkeep=0, tlast=1.
   - tkeep=0x0, tlast=0 -> no tx beat; rx.tready stays 1.
5. Two back-to-back full beats with tx.tready toggling 1,0,1,0 -> 8 segments in order with no bubble when tready=1; tdata/tlast stable during every stall.
6. areset_n driven low after 2 of 4 segments -> tx.tvalid=0 immediately. After release, rx.tready=1 and the next beat starts at segment 0.

Source files
------------

// File: rtl/logic_axi4_stream_pkg.sv
// Shared types and helpers for the logic_axi4_stream family.
// downsize_ratio gives the rx/tx beat width ratio, or 0 when the widths do not divide.
package logic_axi4_stream_pkg;

    function automatic int downsize_ratio(input int rx_bytes, input int tx_bytes);
        if (tx_bytes < 1 || rx_bytes < tx_bytes || (rx_bytes % tx_bytes) != 0)
            return 0;
        return rx_bytes / tx_bytes;
    endfunction

endpackage

// File: rtl/logic_axi4_stream_if.sv
// AXI4-Stream bundle with a receiving (rx) and a sending (tx) view.
// Widths are set per instance so both sides of a width converter share one definition.
interface logic_axi4_stream_if #(
    parameter int TDATA_BYTES = 1,
    parameter int TDEST_WIDTH = 1,
    parameter int TUSER_WIDTH = 1,
    parameter int TID_WIDTH   = 1
) ();
    logic                     tvalid;
    logic                     tready;
    logic [TDATA_BYTES*8-1:0] tdata;
    logic [TDATA_BYTES-1:0]   tkeep;
    logic [TDATA_BYTES-1:0]   tstrb;
    logic                     tlast;
    logic [TID_WIDTH-1:0]     tid;
    logic [TDEST_WIDTH-1:0]   tdest;
    logic [TUSER_WIDTH-1:0]   tuser;

    modport rx (
        input  tvalid, tdata, tkeep, tstrb, tlast, tid, tdest, tuser,
        output tready
    );

    modport tx (
        output tvalid, tdata, tkeep, tstrb, tlast, tid, tdest, tuser,
        input  tready
    );
endinterface

// File: rtl/logic_axi4_stream_downsizer_select.sv
// Find-first-set encoder over a segment mask.
// next_idx is the lowest set bit; is_last means no other bit is set above it.
module logic_axi4_stream_downsizer_select #(
    parameter int RATIO = 4,
    parameter int IDX_W = 2
) (
    input  logic [RATIO-1:0] mask,
    output logic [IDX_W-1:0] next_idx,
    output logic             is_last,
    output logic             any
);

    // Scan from the top so the final hit is the lowest set bit
    always_comb begin
        next_idx = '0;
        is_last  = 1'b1;
        any      = 1'b0;
        for (int i = RATIO - 1; i >= 0; i--) begin
            if (mask[i]) begin
                if (any)
                    is_last = 1'b0;
                any      = 1'b1;
                next_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/logic_axi4_stream_downsizer.sv
// Splits each wide rx beat into narrow tx segments through a one-beat holding register.
// LOGIC_AXI4_STREAM_DOWNSIZER_SKIP_NULL_EN enables null-segment skipping and tlast relocation.
module logic_axi4_stream_downsizer
    import logic_axi4_stream_pkg::*;
#(
    parameter int RX_TDATA_BYTES = 4,
    parameter int TX_TDATA_BYTES = 1,
    parameter int TDEST_WIDTH    = 1,
    parameter int TUSER_WIDTH    = 1,
    parameter int TID_WIDTH      = 1,
    parameter int USE_TLAST      = 1,
    parameter int USE_TKEEP      = 1,
    parameter int USE_TSTRB      = 1
) (
    input logic              aclk,
    input logic              areset_n,
    logic_axi4_stream_if.rx  rx,
    logic_axi4_stream_if.tx  tx
);

    localparam int RATIO = downsize_ratio(RX_TDATA_BYTES, TX_TDATA_BYTES);
    localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int RXW   = RX_TDATA_BYTES * 8;
    localparam int TXW   = TX_TDATA_BYTES * 8;

    if (RATIO < 1) begin : g_bad_ratio
        $error("RX_TDATA_BYTES must be a multiple of TX_TDATA_BYTES");
    end

    logic [RXW-1:0]            hold_data;
    logic [RX_TDATA_BYTES-1:0] hold_keep;
    logic [RX_TDATA_BYTES-1:0] hold_strb;
    logic                      hold_last;
    logic [TID_WIDTH-1:0]      hold_id;
    logic [TDEST_WIDTH-1:0]    hold_dest;
    logic [TUSER_WIDTH-1:0]    hold_user;

    logic             valid_q;
    logic             last_q;
    logic [IDX_W-1:0] idx_q;

    logic [RX_TDATA_BYTES-1:0] rx_keep;
    logic [RX_TDATA_BYTES-1:0] rx_strb;
    logic                      rx_last;
    logic                      rx_fire;
    logic                      tx_fire;

    // Disabled sideband features fall back to their AXI defaults
    always_comb begin
        rx_keep = (USE_TKEEP != 0) ? rx.tkeep : '1;
        rx_strb = (USE_TSTRB != 0) ? rx.tstrb : rx_keep;
        rx_last = (USE_TLAST != 0) && rx.tlast;
    end

    assign rx.tready = !valid_q || (tx.tready && last_q);
    assign rx_fire   = rx.tvalid && rx.tready;
    assign tx_fire   = valid_q && tx.tready;

`ifdef LOGIC_AXI4_STREAM_DOWNSIZER_SKIP_NULL_EN
    logic [RATIO-1:0] pending_q;
    logic [RATIO-1:0] cap_mask;
    logic [RATIO-1:0] rem_mask;
    logic [IDX_W-1:0] cap_idx;
    logic [IDX_W-1:0] adv_idx;
    logic             cap_last;
    logic             adv_last;
    logic             cap_any;
    logic             adv_any;

    // One pending bit per segment with any kept byte; a null closing beat still carries tlast
    always_comb begin
        cap_mask = '0;
        for (int i = 0; i < RATIO; i++)
            cap_mask[i] = |rx_keep[i*TX_TDATA_BYTES +: TX_TDATA_BYTES];
        if (rx_last && (cap_mask == '0))
            cap_mask[0] = 1'b1;
    end

    // Segments still owed once the current one is accepted
    always_comb begin
        rem_mask = '0;
        for (int i = 0; i < RATIO; i++)
            rem_mask[i] = pending_q[i] && (idx_q != IDX_W'(i));
    end

    logic_axi4_stream_downsizer_select #(
        .RATIO (RATIO),
        .IDX_W (IDX_W)
    ) u_cap_sel (
        .mask     (cap_mask),
        .next_idx (cap_idx),
        .is_last  (cap_last),
        .any      (cap_any)
    );

    logic_axi4_stream_downsizer_select #(
        .RATIO (RATIO),
        .IDX_W (IDX_W)
    ) u_adv_sel (
        .mask     (rem_mask),
        .next_idx (adv_idx),
        .is_last  (adv_last),
        .any      (adv_any)
    );
`else
    logic [IDX_W-1:0] nxt_idx;

    assign nxt_idx = idx_q + IDX_W'(1);
`endif

    // Load a new beat, otherwise step to the next segment on each tx handshake
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            idx_q     <= '0;
            hold_data <= '0;
            hold_keep <= '0;
            hold_strb <= '0;
            hold_last <= 1'b0;
            hold_id   <= '0;
            hold_dest <= '0;
            hold_user <= '0;
`ifdef LOGIC_AXI4_STREAM_DOWNSIZER_SKIP_NULL_EN
            pending_q <= '0;
`endif
        end else if (rx_fire) begin
            hold_data <= rx.tdata;
            hold_keep <= rx_keep;
            hold_strb <= rx_strb;
            hold_last <= rx_last;
            hold_id   <= rx.tid;
            hold_dest <= rx.tdest;
            hold_user <= rx.tuser;
`ifdef LOGIC_AXI4_STREAM_DOWNSIZER_SKIP_NULL_EN
            pending_q <= cap_mask;
            idx_q     <= cap_idx;
            last_q    <= cap_last;
            valid_q   <= cap_any;
`else
            idx_q     <= '0;
            last_q    <= (RATIO == 1);
            valid_q   <= 1'b1;
`endif
        end else if (tx_fire) begin
`ifdef LOGIC_AXI4_STREAM_DOWNSIZER_SKIP_NULL_EN
            pending_q <= rem_mask;
            idx_q     <= adv_idx;
            last_q    <= adv_last;
            valid_q   <= adv_any;
`else
            valid_q   <= !last_q;
            idx_q     <= last_q ? '0 : nxt_idx;
            last_q    <= (nxt_idx == IDX_W'(RATIO - 1));
`endif
        end
    end

    assign tx.tvalid = valid_q;
    assign tx.tdata  = hold_data[idx_q*TXW +: TXW];
    assign tx.tkeep  = hold_keep[idx_q*TX_TDATA_BYTES +: TX_TDATA_BYTES];
    assign tx.tstrb  = hold_strb[idx_q*TX_TDATA_BYTES +: TX_TDATA_BYTES];
    assign tx.tlast  = hold_last && last_q;
    assign tx.tid    = hold_id;
    assign tx.tdest  = hold_dest;
    assign tx.tuser  = hold_user;

endmodule

// File: tb/tb_logic_axi4_stream_downsizer.sv
// Directed bench for logic_axi4_stream_downsizer, 4-byte rx to 1-byte tx.
// Expectations follow whether LOGIC_AXI4_STREAM_DOWNSIZER_SKIP_NULL_EN is defined.
module tb_logic_axi4_stream_downsizer;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
        logic [31:0] n;
        logic [31:0] exp_data;
        logic [3:0]  exp_keep;
        logic [3:0]  exp_last;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    logic_axi4_stream_if #(.TDATA_BYTES(4)) rx_if ();
    logic_axi4_stream_if #(.TDATA_BYTES(1)) tx_if ();

    logic_axi4_stream_downsizer #(
        .RX_TDATA_BYTES (4),
        .TX_TDATA_BYTES (1)
    ) dut (
        .aclk     (clk),
        .areset_n (rst_n),
        .rx       (rx_if),
        .tx       (tx_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    vec_t        vt[7];
    logic [31:0] s_data[4];
    logic [3:0]  s_keep[4];
    logic        s_last[4];
    int          s_nb;
    logic [7:0]  e_data[16];
    logic        e_last[16];
    int          e_n;
    logic [3:0]  pat;

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic vec_t mk(input logic [31:0] d, input logic [3:0] k,
                                input logic l, input int n,
                                input logic [31:0] ed, input logic [3:0] ek,
                                input logic [3:0] el);
        vec_t v;
        v.data = d; v.keep = k; v.last = l; v.n = n;
        v.exp_data = ed; v.exp_keep = ek; v.exp_last = el;
        return v;
    endfunction

    task automatic drive_rx(input logic [31:0] d, input logic [3:0] k,
                            input logic l, input logic [2:0] side);
        rx_if.tvalid = 1'b1;
        rx_if.tdata  = d;
        rx_if.tkeep  = k;
        rx_if.tstrb  = k;
        rx_if.tlast  = l;
        rx_if.tid    = side[2];
        rx_if.tdest  = side[1];
        rx_if.tuser  = side[0];
    endtask

    task automatic idle_check(input string name);
        for (int c = 0; c < 2; c++) begin
            #1;
            chk({name, " idle_tvalid"}, 32'(tx_if.tvalid), 32'd0);
            chk({name, " idle_rx_tready"}, 32'(rx_if.tready), 32'd1);
            @(negedge clk);
        end
    endtask

    task automatic run_vec(input vec_t v, input int tag);
        int   got;
        int   cyc;
        bit   sent;
        logic [2:0] side;
        side = tag[2:0];
        got  = 0;
        cyc  = 0;
        sent = 0;
        @(negedge clk);
        tx_if.tready = 1'b1;
        drive_rx(v.data, v.keep, v.last, side);
        while ((!sent || got < int'(v.n)) && cyc < 20) begin
            #1;
            if (tx_if.tvalid) begin
                if (got < int'(v.n)) begin
                    chk($sformatf("vec%0d seg%0d tdata", tag, got),
                        32'(tx_if.tdata), 32'(v.exp_data[got*8 +: 8]));
                    chk($sformatf("vec%0d seg%0d tkeep", tag, got),
                        {30'd0, tx_if.tkeep, tx_if.tstrb},
                        {30'd0, v.exp_keep[got], v.exp_keep[got]});
                    chk($sformatf("vec%0d seg%0d tlast", tag, got),
                        32'(tx_if.tlast), 32'(v.exp_last[got]));
                    chk($sformatf("vec%0d seg%0d side", tag, got),
                        32'({tx_if.tid, tx_if.tdest, tx_if.tuser}), 32'(side));
                end else begin
                    chk($sformatf("vec%0d extra_seg", tag), 32'd1, 32'd0);
                end
                got++;
            end
            if (rx_if.tvalid && rx_if.tready)
                sent = 1;
            @(negedge clk);
            cyc++;
            if (sent)
                rx_if.tvalid = 1'b0;
        end
        rx_if.tvalid = 1'b0;
        chk($sformatf("vec%0d seg_count", tag), 32'(got), v.n);
        chk($sformatf("vec%0d accepted", tag), 32'(sent), 32'd1);
        idle_check($sformatf("vec%0d", tag));
    endtask

    task automatic run_stream(input string name);
        int   bi;
        int   ei;
        int   cyc;
        bit   stall;
        bit   started;
        bit   fire;
        logic [7:0] pd;
        logic pl;
        bi = 0; ei = 0; cyc = 0; stall = 0; started = 0;
        pd = '0; pl = 1'b0;
        @(negedge clk);
        drive_rx(s_data[0], s_keep[0], s_last[0], 3'd0);
        while (ei < e_n && cyc < 60) begin
            tx_if.tready = pat[cyc % 4];
            #1;
            if (stall)
                chk({name, " stall_hold"}, 32'({tx_if.tvalid, tx_if.tdata, tx_if.tlast}),
                    32'({1'b1, pd, pl}));
            if (started)
                chk({name, " no_bubble"}, 32'(tx_if.tvalid), 32'd1);
            stall = 0;
            if (tx_if.tvalid) begin
                started = 1;
                if (tx_if.tready) begin
                    chk($sformatf("%s seg%0d tdata", name, ei), 32'(tx_if.tdata),
                        32'(e_data[ei]));
                    chk($sformatf("%s seg%0d tlast", name, ei), 32'(tx_if.tlast),
                        32'(e_last[ei]));
                    ei++;
                end else begin
                    stall = 1;
                    pd = tx_if.tdata;
                    pl = tx_if.tlast;
                end
            end
            fire = rx_if.tvalid && rx_if.tready;
            @(negedge clk);
            cyc++;
            if (fire) begin
                bi++;
                if (bi < s_nb)
                    drive_rx(s_data[bi], s_keep[bi], s_last[bi], 3'd0);
                else
                    rx_if.tvalid = 1'b0;
            end
        end
        rx_if.tvalid = 1'b0;
        tx_if.tready = 1'b1;
        chk({name, " seg_count"}, 32'(ei), 32'(e_n));
        idle_check(name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish within time limit");
        $fatal(1);
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        rx_if.tvalid = 1'b0;
        rx_if.tdata  = '0;
        rx_if.tkeep  = '0;
        rx_if.tstrb  = '0;
        rx_if.tlast  = 1'b0;
        rx_if.tid    = '0;
        rx_if.tdest  = '0;
        rx_if.tuser  = '0;
        tx_if.tready = 1'b0;

`ifdef LOGIC_AXI4_STREAM_DOWNSIZER_SKIP_NULL_EN
        vt[0] = mk(32'h44332211, 4'hF, 1'b1, 4, 32'h44332211, 4'hF, 4'h8);
        vt[1] = mk(32'h44332211, 4'h5, 1'b0, 2, 32'h00003311, 4'h3, 4'h0);
        vt[2] = mk(32'h44332211, 4'h3, 1'b1, 2, 32'h00002211, 4'h3, 4'h2);
        vt[3] = mk(32'h44332211, 4'h0, 1'b1, 1, 32'h00000011, 4'h0, 4'h1);
        vt[4] = mk(32'h44332211, 4'h0, 1'b0, 0, 32'h00000000, 4'h0, 4'h0);
        vt[5] = mk(32'hDDCCBBAA, 4'h4, 1'b1, 1, 32'h000000CC, 4'h1, 4'h1);
        vt[6] = mk(32'hDDCCBBAA, 4'hA, 1'b1, 2, 32'h0000DDBB, 4'h3, 4'h2);
`else
        vt[0] = mk(32'h44332211, 4'hF, 1'b1, 4, 32'h44332211, 4'hF, 4'h8);
        vt[1] = mk(32'h44332211, 4'h5, 1'b0, 4, 32'h44332211, 4'h5, 4'h0);
        vt[2] = mk(32'h44332211, 4'h3, 1'b1, 4, 32'h44332211, 4'h3, 4'h8);
        vt[3] = mk(32'h44332211, 4'h0, 1'b1, 4, 32'h44332211, 4'h0, 4'h8);
        vt[4] = mk(32'h44332211, 4'h0, 1'b0, 4, 32'h44332211, 4'h0, 4'h0);
        vt[5] = mk(32'hDDCCBBAA, 4'h4, 1'b1, 4, 32'hDDCCBBAA, 4'h4, 4'h8);
        vt[6] = mk(32'hDDCCBBAA, 4'hA, 1'b1, 4, 32'hDDCCBBAA, 4'hA, 4'h8);
`endif

        repeat (3) @(negedge clk);
        #1;
        chk("reset tvalid", 32'(tx_if.tvalid), 32'd0);
        chk("reset rx_tready", 32'(rx_if.tready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        tx_if.tready = 1'b1;

        for (int i = 0; i < 7; i++)
            run_vec(vt[i], i);

        // Full beat: one-cycle latency, rx.tready low until the final segment
        @(negedge clk);
        drive_rx(32'h44332211, 4'hF, 1'b1, 3'd0);
        #1;
        chk("full rx_tready_idle", 32'(rx_if.tready), 32'd1);
        @(negedge clk);
        rx_if.tvalid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("full seg%0d tvalid", k), 32'(tx_if.tvalid), 32'd1);
            chk($sformatf("full seg%0d tdata", k), 32'(tx_if.tdata), 32'(8'h11 * (k + 1)));
            chk($sformatf("full seg%0d rx_tready", k), 32'(rx_if.tready), 32'(k == 3));
            @(negedge clk);
        end
        idle_check("full");

        // Two full beats with tready toggling
        s_nb = 2;
        s_data[0] = 32'h44332211; s_keep[0] = 4'hF; s_last[0] = 1'b0;
        s_data[1] = 32'h88776655; s_keep[1] = 4'hF; s_last[1] = 1'b1;
        e_n = 8;
        for (int k = 0; k < 8; k++) begin
            e_data[k] = 8'(8'h11 * (k + 1));
            e_last[k] = (k == 7);
        end
        pat = 4'b0101;
        run_stream("toggle");

        // Trimmed tlast beat followed immediately by a full beat
        s_data[0] = 32'h44332211; s_keep[0] = 4'h3; s_last[0] = 1'b1;
        s_data[1] = 32'h88776655; s_keep[1] = 4'hF; s_last[1] = 1'b1;
        pat = 4'b1111;
`ifdef LOGIC_AXI4_STREAM_DOWNSIZER_SKIP_NULL_EN
        e_n = 6;
        e_data[0] = 8'h11; e_last[0] = 1'b0;
        e_data[1] = 8'h22; e_last[1] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            e_data[2 + k] = 8'(8'h55 + 8'h11 * k);
            e_last[2 + k] = (k == 3);
        end
`else
        e_n = 8;
        for (int k = 0; k < 8; k++) begin
            e_data[k] = 8'(8'h11 * (k + 1));
            e_last[k] = (k == 3) || (k == 7);
        end
`endif
        run_stream("b2b");

        // Reset with half a beat still owed
        @(negedge clk);
        tx_if.tready = 1'b1;
        drive_rx(32'h88776655, 4'hF, 1'b1, 3'd0);
        @(negedge clk);
        rx_if.tvalid = 1'b0;
        #1;
        chk("rst seg0 tdata", 32'(tx_if.tdata), 32'h55);
        @(negedge clk);
        #1;
        chk("rst seg1 tdata", 32'(tx_if.tdata), 32'h66);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst async tvalid", 32'(tx_if.tvalid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst release rx_tready", 32'(rx_if.tready), 32'd1);
        chk("rst release tvalid", 32'(tx_if.tvalid), 32'd0);
        run_vec(vt[0], 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
